// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter and sequencer that connects two command ports to a single-port RAM.
// Read data is captured a fixed number of cycles after access and returned on a tagged response port.
module sp_ram_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 30,
  parameter int RD_LATENCY    = 1   // legal range 1..7
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_we,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]    req0_wdata,

  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_we,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]    req1_wdata,

  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [DATA_WIDTH-1:0]    rsp_data,

  output logic                     ram_cs,
  output logic                     ram_oe,
  output logic                     ram_read_write,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,

  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

  state_t     r_state;
  logic       r_rr_ptr;
  logic       r_we;
  logic       r_id;
  logic [2:0] r_cnt;

  logic                     w_sel;
  logic                     w_accept;
  logic                     w_we;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]    w_wdata;

  // A lone requester wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    w_sel = r_rr_ptr;
    if (req0_valid && !req1_valid)
      w_sel = 1'b0;
    else if (req1_valid && !req0_valid)
      w_sel = 1'b1;
  end

  assign w_accept = rst_n && (r_state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = w_accept && (w_sel == 1'b0);
  assign req1_ready = w_accept && (w_sel == 1'b1);

  assign w_we    = w_sel ? req1_we    : req0_we;
  assign w_addr  = w_sel ? req1_addr  : req0_addr;
  assign w_wdata = w_sel ? req1_wdata : req0_wdata;

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_rr_ptr       <= 1'b0;
      r_we           <= 1'b0;
      r_id           <= 1'b0;
      r_cnt          <= 3'd0;
      ram_cs         <= 1'b0;
      ram_oe         <= 1'b0;
      ram_read_write <= 1'b0;
      ram_address    <= '0;
      ram_wdata      <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_data       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we           <= w_we;
            r_id           <= w_sel;
            r_rr_ptr       <= ~w_sel;
            ram_cs         <= 1'b1;
            ram_read_write <= w_we;
            ram_oe         <= ~w_we;
            ram_address    <= w_addr;
            ram_wdata      <= w_we ? w_wdata : '0;
            r_state        <= ACCESS;
          end
        end
        ACCESS: begin
          // Address stays on the bus so the RAM sees a stable address through the read wait.
          ram_cs         <= 1'b0;
          ram_oe         <= 1'b0;
          ram_read_write <= 1'b0;
          if (r_we) begin
            r_state <= IDLE;
          end else begin
            r_cnt   <= CNT_INIT;
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (r_cnt == 3'd0) begin
            rsp_data  <= ram_rdata;
            rsp_id    <= r_id;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter: one instance at RD_LATENCY=1, one at RD_LATENCY=3,
// each attached to a small behavioural RAM that drives read data only in its valid cycle.
module tb_sp_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A, RD_LATENCY = 1 ----------------
  logic        a_rst_n;
  logic        a_req0_valid, a_req0_ready, a_req0_we;
  logic [29:0] a_req0_addr;
  logic [7:0]  a_req0_wdata;
  logic        a_req1_valid, a_req1_ready, a_req1_we;
  logic [29:0] a_req1_addr;
  logic [7:0]  a_req1_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_id;
  logic [7:0]  a_rsp_data;
  logic        a_ram_cs, a_ram_oe, a_ram_rw;
  logic [29:0] a_ram_address;
  logic [7:0]  a_ram_wdata, a_ram_rdata;
  logic        a_busy;

  sp_ram_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(30), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst_n(a_rst_n),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_we(a_req0_we),
    .req0_addr(a_req0_addr), .req0_wdata(a_req0_wdata),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_we(a_req1_we),
    .req1_addr(a_req1_addr), .req1_wdata(a_req1_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_id(a_rsp_id), .rsp_data(a_rsp_data),
    .ram_cs(a_ram_cs), .ram_oe(a_ram_oe), .ram_read_write(a_ram_rw),
    .ram_address(a_ram_address), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
    .busy(a_busy)
  );

  logic [7:0] mem_a [256];
  logic [2:0] a_dly = 3'd0;
  logic [7:0] a_raddr = 8'd0;
  always @(posedge clk) begin
    if (a_ram_cs && a_ram_rw) mem_a[a_ram_address[7:0]] <= a_ram_wdata;
    if (a_ram_cs && a_ram_oe) begin
      a_dly   <= 3'd1;
      a_raddr <= a_ram_address[7:0];
    end else if (a_dly != 3'd0) begin
      a_dly <= a_dly - 3'd1;
    end
  end
  assign a_ram_rdata = (a_dly == 3'd1) ? mem_a[a_raddr] : 8'hxx;

  // ---------------- instance B, RD_LATENCY = 3 ----------------
  logic        b_rst_n;
  logic        b_req0_valid, b_req0_ready, b_req0_we;
  logic [29:0] b_req0_addr;
  logic [7:0]  b_req0_wdata;
  logic        b_req1_valid, b_req1_ready, b_req1_we;
  logic [29:0] b_req1_addr;
  logic [7:0]  b_req1_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_id;
  logic [7:0]  b_rsp_data;
  logic        b_ram_cs, b_ram_oe, b_ram_rw;
  logic [29:0] b_ram_address;
  logic [7:0]  b_ram_wdata, b_ram_rdata;
  logic        b_busy;

  sp_ram_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(30), .RD_LATENCY(3)) u_b (
    .clk(clk), .rst_n(b_rst_n),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_we(b_req0_we),
    .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_we(b_req1_we),
    .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
    .ram_cs(b_ram_cs), .ram_oe(b_ram_oe), .ram_read_write(b_ram_rw),
    .ram_address(b_ram_address), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
    .busy(b_busy)
  );

  logic [7:0] mem_b [256];
  logic [2:0] b_dly = 3'd0;
  logic [7:0] b_raddr = 8'd0;
  always @(posedge clk) begin
    if (b_ram_cs && b_ram_rw) mem_b[b_ram_address[7:0]] <= b_ram_wdata;
    if (b_ram_cs && b_ram_oe) begin
      b_dly   <= 3'd3;
      b_raddr <= b_ram_address[7:0];
    end else if (b_dly != 3'd0) begin
      b_dly <= b_dly - 3'd1;
    end
  end
  assign b_ram_rdata = (b_dly == 3'd1) ? mem_b[b_raddr] : 8'hxx;

  // ---------------- stimulus ----------------
  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_req0_valid = 0; a_req0_we = 0; a_req0_addr = '0; a_req0_wdata = '0;
    a_req1_valid = 0; a_req1_we = 0; a_req1_addr = '0; a_req1_wdata = '0;
    a_rsp_ready = 0;
    b_req0_valid = 0; b_req0_we = 0; b_req0_addr = '0; b_req0_wdata = '0;
    b_req1_valid = 0; b_req1_we = 0; b_req1_addr = '0; b_req1_wdata = '0;
    b_rsp_ready = 0;

    // Reset state; ready must stay low during reset even with a valid command.
    step(); step();
    a_req0_valid = 1; a_req1_valid = 1;
    #1;
    chk("rst_ready0", a_req0_ready, 0);
    chk("rst_ready1", a_req1_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_cs", a_ram_cs, 0);
    chk("rst_oe", a_ram_oe, 0);
    chk("rst_rw", a_ram_rw, 0);
    chk("rst_addr", a_ram_address, 0);
    chk("rst_wdata", a_ram_wdata, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_id", a_rsp_id, 0);
    chk("rst_rsp_data", a_rsp_data, 0);
    a_req0_valid = 0; a_req1_valid = 0;
    a_rst_n = 1; b_rst_n = 1;
    step();

    // Single write from requester 0.
    a_req0_valid = 1; a_req0_we = 1; a_req0_addr = 30'h0000_1234; a_req0_wdata = 8'hA5;
    #1;
    chk("wr_ready0", a_req0_ready, 1);
    chk("wr_ready1", a_req1_ready, 0);
    step();
    a_req0_valid = 0;
    chk("wr_cs", a_ram_cs, 1);
    chk("wr_rw", a_ram_rw, 1);
    chk("wr_oe", a_ram_oe, 0);
    chk("wr_addr", a_ram_address, 30'h1234);
    chk("wr_wdata", a_ram_wdata, 8'hA5);
    chk("wr_busy_access", a_busy, 1);
    step();
    chk("wr_busy_done", a_busy, 0);
    chk("wr_cs_done", a_ram_cs, 0);

    // Write then read-back of the top address, read issued by requester 1.
    a_req0_valid = 1; a_req0_we = 1; a_req0_addr = 30'h3FFF_FFFF; a_req0_wdata = 8'h5A;
    step();
    a_req0_valid = 0;
    chk("raw_wr_cs", a_ram_cs, 1);
    step();
    a_rsp_ready = 1;
    a_req1_valid = 1; a_req1_we = 0; a_req1_addr = 30'h3FFF_FFFF;
    #1;
    chk("raw_ready1", a_req1_ready, 1);
    step();
    a_req1_valid = 0;
    chk("raw_rd_cs", a_ram_cs, 1);
    chk("raw_rd_oe", a_ram_oe, 1);
    chk("raw_rd_rw", a_ram_rw, 0);
    chk("raw_rd_wdata", a_ram_wdata, 0);
    chk("raw_rd_addr", a_ram_address, 30'h3FFF_FFFF);
    step();
    chk("raw_wait_valid", a_rsp_valid, 0);
    chk("raw_wait_cs", a_ram_cs, 0);
    chk("raw_wait_oe", a_ram_oe, 0);
    chk("raw_wait_addr_hold", a_ram_address, 30'h3FFF_FFFF);
    step();
    chk("raw_rsp_valid", a_rsp_valid, 1);
    chk("raw_rsp_id", a_rsp_id, 1);
    chk("raw_rsp_data", a_rsp_data, 8'h5A);
    step();
    chk("raw_rsp_done", a_rsp_valid, 0);
    chk("raw_busy_done", a_busy, 0);

    // Simultaneous writes: grants alternate starting with requester 0 after reset.
    a_rst_n = 0;
    step();
    a_rst_n = 1;
    a_req0_valid = 1; a_req0_we = 1; a_req0_addr = 30'h100; a_req0_wdata = 8'h11;
    a_req1_valid = 1; a_req1_we = 1; a_req1_addr = 30'h200; a_req1_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_ready0_%0d", i), a_req0_ready, (i % 2 == 0));
      chk($sformatf("rr_ready1_%0d", i), a_req1_ready, (i % 2 == 1));
      step();
      chk($sformatf("rr_addr_%0d", i), a_ram_address, (i % 2 == 0) ? 30'h100 : 30'h200);
      chk($sformatf("rr_wdata_%0d", i), a_ram_wdata, (i % 2 == 0) ? 8'h11 : 8'h22);
      chk($sformatf("rr_acc_ready0_%0d", i), a_req0_ready, 0);
      chk($sformatf("rr_acc_ready1_%0d", i), a_req1_ready, 0);
      step();
    end
    a_req0_valid = 0; a_req1_valid = 0;

    // Response backpressure on a read of 0x1234 (holds 0xA5).
    a_rsp_ready = 0;
    a_req0_valid = 1; a_req0_we = 0; a_req0_addr = 30'h1234;
    #1;
    chk("bp_ready0", a_req0_ready, 1);
    step();
    a_req0_we = 1; a_req0_addr = 30'h777; a_req0_wdata = 8'hEE;
    a_req1_valid = 1;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), a_rsp_valid, 1);
      chk($sformatf("bp_data_%0d", i), a_rsp_data, 8'hA5);
      chk($sformatf("bp_id_%0d", i), a_rsp_id, 0);
      chk($sformatf("bp_ready0_%0d", i), a_req0_ready, 0);
      chk($sformatf("bp_ready1_%0d", i), a_req1_ready, 0);
      chk($sformatf("bp_cs_%0d", i), a_ram_cs, 0);
      step();
    end
    a_rsp_ready = 1;
    step();
    a_req0_valid = 0; a_req1_valid = 0;
    chk("bp_done_busy", a_busy, 0);
    chk("bp_done_valid", a_rsp_valid, 0);

    // Reset while waiting for read data: nothing is returned afterwards.
    a_req0_valid = 1; a_req0_we = 0; a_req0_addr = 30'h1234;
    step();
    a_req0_valid = 0;
    step();
    chk("mr_busy_wait", a_busy, 1);
    a_rst_n = 0;
    step();
    chk("mr_busy", a_busy, 0);
    chk("mr_cs", a_ram_cs, 0);
    chk("mr_addr", a_ram_address, 0);
    chk("mr_rsp_valid", a_rsp_valid, 0);
    chk("mr_rsp_data", a_rsp_data, 0);
    a_rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mr_no_rsp_%0d", i), a_rsp_valid, 0);
    end

    // RD_LATENCY=3: capture exactly three edges after the access edge.
    b_rsp_ready = 1;
    b_req0_valid = 1; b_req0_we = 1; b_req0_addr = 30'h10; b_req0_wdata = 8'hC3;
    step();
    b_req0_valid = 0;
    step();
    b_req1_valid = 1; b_req1_we = 0; b_req1_addr = 30'h10;
    #1;
    chk("l3_ready1", b_req1_ready, 1);
    step();
    b_req1_valid = 0;
    chk("l3_cs", b_ram_cs, 1);
    chk("l3_oe", b_ram_oe, 1);
    step();
    chk("l3_wait1", b_rsp_valid, 0);
    chk("l3_cs_off", b_ram_cs, 0);
    step();
    chk("l3_wait2", b_rsp_valid, 0);
    step();
    chk("l3_wait3", b_rsp_valid, 0);
    step();
    chk("l3_rsp_valid", b_rsp_valid, 1);
    chk("l3_rsp_data", b_rsp_data, 8'hC3);
    chk("l3_rsp_id", b_rsp_id, 1);
    step();
    chk("l3_busy_done", b_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the single-port RAM (8-bit data, 30-bit address, cs/oe/read_write control).
- Accepts one command at a time from two valid/ready command ports.
- Drives the RAM control, address and write-data pins from registers.
- Captures read data after a fixed latency and returns it on a single valid/ready response port, tagged with the requester ID.
- Sits between the traffic sources and the RAM; the RAM assertion checker monitors its RAM-side pins.

Parameters:
- DATA_WIDTH, 8, RAM data width.
- ADDRESS_WIDTH, 30, RAM address width.
- RD_LATENCY, 1, cycles from the RAM read-access edge to valid ram_rdata; legal range 1..7.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_we  in  1  1=write, 0=read.
- req0_addr  in  ADDRESS_WIDTH  requester 0 address.
- req0_wdata  in  DATA_WIDTH  requester 0 write data.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata: same widths and meaning for requester 1.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that issued the read.
- rsp_data  out  DATA_WIDTH  read data.
- ram_cs  out  1  RAM chip select.
- ram_oe  out  1  RAM output enable.
- ram_read_write  out  1  1=write, 0=read.
- ram_address  out  ADDRESS_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data; the external tri-state drives the RAM data bus when ram_read_write=1.
- ram_rdata  in  DATA_WIDTH  RAM read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0 (requester 0 favoured).
  - All ram_* outputs = 0; rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req*_ready=0 while rst_n=0.
  - Reset mid-operation aborts any access or pending response; nothing is replayed.
- State machine: IDLE -> ACCESS -> (write: IDLE | read: RD_WAIT -> RESP -> IDLE).
- IDLE:
  - reqN_ready is combinational and high only for the selected requester.
  - Selection: if exactly one reqN_valid is high, select it. If both are high, select rr_ptr.
  - On valid&&ready: latch we/addr/wdata/id, set rr_ptr to the other requester, go to ACCESS.
  - The non-selected requester sees ready=0 and must hold its command.
- ACCESS (exactly 1 cycle):
  - Registered outputs: ram_cs=1, ram_read_write=we, ram_oe=~we, ram_address=addr, ram_wdata=wdata (0 on reads).
  - Write: next state IDLE, no response generated.
  - Read: next state RD_WAIT with cnt=RD_LATENCY-1.
- RD_WAIT:
  - ram_cs, ram_oe and ram_read_write return to 0.
  - ram_address holds its last value.
  - cnt decrements each cycle.
  - When cnt==0, capture ram_rdata into rsp_data, set rsp_valid=1 and rsp_id, go to RESP.
  - The capture edge is RD_LATENCY edges after the ACCESS edge.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready=1.
  - On the handshake edge: rsp_valid->0, go to IDLE.
  - No new command is accepted while in RESP (full backpressure).
- Invariants:
  - ram_oe and ram_read_write are never both 1.
  - ram_oe=1 implies ram_cs=1.
  - ram_cs is high for exactly one cycle per accepted command.
  - At most one command is in flight.
- Throughput:
  - Write: 2 cycles (IDLE accept + ACCESS).
  - Read with rsp_ready held high: 3+RD_LATENCY cycles to return to IDLE.
- A write followed by a read to the same address is ordered: the read issues strictly after the write's ACCESS cycle.

Test Plan:
- Reset mid-read: assert rst_n=0 while in RD_WAIT -> next edge all outputs 0, busy=0, no rsp_valid pulse afterwards.
- Single write: req0 write addr=0x0000_1234, data=0xA5 -> req0_ready=1 in cycle 0. Cycle 1: ram_cs=1, ram_read_write=1, ram_oe=0, ram_address=0x1234, ram_wdata=0xA5. Cycle 2: busy=0.
- Read-after-write, RD_LATENCY=1: write 0x5A to 0x3FFF_FFFF, then req1 read of the same address with RAM model returning 0x5A -> rsp_valid=1, rsp_id=1, rsp_data=0x5A, two edges after the read accept edge.
- Simultaneous requests: both valid every cycle with writes -> grants alternate 0,1,0,1. The first grant goes to req0 after reset. No ram_cs cycle has both requesters' addresses.
- Response backpressure: read issued with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_id stable for those 5 cycles, req*_ready=0 throughout, IDLE one edge after rsp_ready=1.
- RD_LATENCY=3: single read of addr 0x10 -> rsp_data is sampled exactly 3 edges after the ACCESS edge. Data is from the RAM model, with X on ram_rdata outside that cycle.
